lct_l1a_event_sequencer: RTL and testbench

Synthesisable, parametrised timestamped trigger-pattern player. It holds up to DEPTH events, each a timestamp plus L1A / ALCT_DAV / TMB_DAV / per-DCFEB LCT bits, and replays them on the ODMB trigger inputs when its free-running timestamp counter matches. It supports single-shot and looping modes and flags events whose timestamp has already passed. It sits in the test/trigger path ahead of the L1A/LCT matching logic, driven by VME-loaded sequences.

---
 rtl/odmb_seq_pkg.sv | 34 +++
 rtl/seq_event_ram.sv | 33 +++
 rtl/lct_l1a_event_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_lct_l1a_event_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/odmb_seq_pkg.sv
// Purpose : shared FSM encoding and event-entry layout for the trigger-pattern player.
// Latency : n/a (types and constant helpers only).
// Backpressure: n/a.
// Entry layout, LSB first: lct[NCH-1:0], tmb_dav, alct_dav, l1a, ts[TS_W-1:0].
package odmb_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  function automatic int ent_w(input int nch, input int ts_w);
    return ts_w + 3 + nch;
  endfunction

  function automatic int off_tmb(input int nch);
    return nch;
  endfunction

  function automatic int off_alct(input int nch);
    return nch + 1;
  endfunction

  function automatic int off_l1a(input int nch);
    return nch + 2;
  endfunction

  function automatic int off_ts(input int nch);
    return nch + 3;
  endfunction

endpackage

// File: rtl/seq_event_ram.sv
// Purpose : simple dual-port event memory, one write port and one registered read port.
// Latency : read data valid one cycle after i_rd_addr; write visible to reads from the next cycle.
// Backpressure: none; both ports accept every cycle. Contents are not reset.
// Ports   : i_clk; i_wr_en/i_wr_addr/i_wr_dat write port; i_rd_addr -> o_rd_dat registered read.
module seq_event_ram #(
  parameter int DEPTH = 64,
  parameter int W     = 42,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_dat,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_dat
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rd_dat;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    r_rd_dat <= r_mem[i_rd_addr];
  end

  assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/lct_l1a_event_sequencer.sv
// Purpose : timestamped trigger-pattern player; replays stored L1A/ALCT/TMB/LCT events
//           when a free-running timestamp counter reaches each entry's timestamp.
// Latency : start -> FETCH -> RUN(ts_cnt=0); an event with ts=k fires 3+k cycles after start.
// Backpressure: none; en pauses the counter, stop aborts, writes are dropped while busy.
// Ports   : wr_* load entries (IDLE only); n_events/loop_mode/start/stop/en control playback;
//           l1a/alct_dav/tmb_dav/lct registered event pulses; busy/done/late_err/ev_ptr status.
module lct_l1a_event_sequencer
  import odmb_seq_pkg::*;
#(
  parameter int NCH   = 7,
  parameter int DEPTH = 64,
  parameter int TS_W  = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [TS_W-1:0] wr_ts,
  input  logic            wr_l1a,
  input  logic            wr_alct_dav,
  input  logic            wr_tmb_dav,
  input  logic [NCH-1:0]  wr_lct,
  input  logic [AW:0]     n_events,
  input  logic            loop_mode,
  input  logic            start,
  input  logic            stop,
  input  logic            en,
  output logic            l1a,
  output logic            alct_dav,
  output logic            tmb_dav,
  output logic [NCH-1:0]  lct,
  output logic            busy,
  output logic            done,
  output logic            late_err,
  output logic [AW-1:0]   ev_ptr
);

  localparam int EW       = ent_w(NCH, TS_W);
  localparam int OFF_TMB  = off_tmb(NCH);
  localparam int OFF_ALCT = off_alct(NCH);
  localparam int OFF_L1A  = off_l1a(NCH);
  localparam int OFF_TS   = off_ts(NCH);

  seq_state_t      r_state;
  logic [TS_W-1:0] r_ts_cnt;
  logic [AW-1:0]   r_ptr;
  logic [AW:0]     r_last_idx;
  logic            r_loop;
  logic            r_l1a;
  logic            r_alct;
  logic            r_tmb;
  logic [NCH-1:0]  r_lct;
  logic            r_busy;
  logic            r_done;
  logic            r_late;

  logic            w_wr_en;
  logic [EW-1:0]   w_wr_dat;
  logic [AW-1:0]   w_rd_addr;
  logic [EW-1:0]   w_rd_dat;
  logic [TS_W-1:0] w_head_ts;
  logic            w_fire;
  logic            w_late;
  logic            w_last;

  assign w_wr_en  = wr_en && (r_state == ST_IDLE);
  assign w_wr_dat = {wr_ts, wr_l1a, wr_alct_dav, wr_tmb_dav, wr_lct};

  seq_event_ram #(
    .DEPTH (DEPTH),
    .W     (EW),
    .AW    (AW)
  ) u_ram (
    .i_clk     (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_dat  (w_wr_dat),
    .i_rd_addr (w_rd_addr),
    .o_rd_dat  (w_rd_dat)
  );

  // The RAM output register doubles as the head-entry register: it always holds
  // the entry at the address presented in the previous cycle.
  assign w_head_ts = w_rd_dat[OFF_TS +: TS_W];

  // A head already in the past fires as soon as the counter is enabled.
  assign w_late = (w_head_ts < r_ts_cnt);
  assign w_fire = (r_state == ST_RUN) && en && (w_head_ts <= r_ts_cnt);
  assign w_last = ({1'b0, r_ptr} == r_last_idx);

  // Read address runs one step ahead on a fire so back-to-back events need no bubble.
  always_comb begin
    w_rd_addr = r_ptr;
    case (r_state)
      ST_IDLE, ST_FETCH: w_rd_addr = '0;
      ST_RUN: begin
        if (w_fire) begin
          w_rd_addr = w_last ? '0 : r_ptr + 1'b1;
        end
      end
      default: w_rd_addr = r_ptr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ts_cnt   <= '0;
      r_ptr      <= '0;
      r_last_idx <= '0;
      r_loop     <= 1'b0;
      r_l1a      <= 1'b0;
      r_alct     <= 1'b0;
      r_tmb      <= 1'b0;
      r_lct      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_late     <= 1'b0;
    end else begin
      // Event outputs and done are single-cycle pulses.
      r_l1a  <= 1'b0;
      r_alct <= 1'b0;
      r_tmb  <= 1'b0;
      r_lct  <= '0;
      r_done <= 1'b0;
      if (stop) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && (n_events != '0)) begin
              r_state    <= ST_FETCH;
              r_busy     <= 1'b1;
              r_ts_cnt   <= '0;
              r_ptr      <= '0;
              r_late     <= 1'b0;
              r_last_idx <= n_events - 1'b1;
              r_loop     <= loop_mode;
            end
          end
          ST_FETCH: begin
            r_state <= ST_RUN;
          end
          ST_RUN: begin
            if (en && !(&r_ts_cnt)) begin
              r_ts_cnt <= r_ts_cnt + 1'b1;
            end
            if (w_fire) begin
              r_l1a  <= w_rd_dat[OFF_L1A];
              r_alct <= w_rd_dat[OFF_ALCT];
              r_tmb  <= w_rd_dat[OFF_TMB];
              r_lct  <= w_rd_dat[NCH-1:0];
              if (w_late) begin
                r_late <= 1'b1;
              end
              if (w_last) begin
                if (r_loop) begin
                  r_ptr    <= '0;
                  r_ts_cnt <= '0;
                  r_state  <= ST_FETCH;
                end else begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                end
              end else begin
                r_ptr <= r_ptr + 1'b1;
              end
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign l1a      = r_l1a;
  assign alct_dav = r_alct;
  assign tmb_dav  = r_tmb;
  assign lct      = r_lct;
  assign busy     = r_busy;
  assign done     = r_done;
  assign late_err = r_late;
  assign ev_ptr   = r_ptr;

endmodule

// File: tb/tb_lct_l1a_event_sequencer.sv
// Purpose : randomized and directed playback scenarios checked against an event-timeline model.
// Latency : n/a.
// Backpressure: n/a.
module tb_lct_l1a_event_sequencer;

  localparam int NCH   = 7;
  localparam int DEPTH = 8;
  localparam int TS_W  = 16;
  localparam int AW    = 3;
  localparam int MAXC  = 256;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [TS_W-1:0] wr_ts = '0;
  logic            wr_l1a = 1'b0, wr_alct_dav = 1'b0, wr_tmb_dav = 1'b0;
  logic [NCH-1:0]  wr_lct = '0;
  logic [AW:0]     n_events = '0;
  logic            loop_mode = 1'b0, start = 1'b0, stop = 1'b0, en = 1'b1;
  logic            l1a, alct_dav, tmb_dav, busy, done, late_err;
  logic [NCH-1:0]  lct;
  logic [AW-1:0]   ev_ptr;

  lct_l1a_event_sequencer #(.NCH(NCH), .DEPTH(DEPTH), .TS_W(TS_W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_ts(wr_ts),
    .wr_l1a(wr_l1a), .wr_alct_dav(wr_alct_dav), .wr_tmb_dav(wr_tmb_dav), .wr_lct(wr_lct),
    .n_events(n_events), .loop_mode(loop_mode), .start(start), .stop(stop), .en(en),
    .l1a(l1a), .alct_dav(alct_dav), .tmb_dav(tmb_dav), .lct(lct),
    .busy(busy), .done(done), .late_err(late_err), .ev_ptr(ev_ptr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bench copy of everything written into the DUT memory while idle.
  int             m_ts   [DEPTH];
  bit             m_l1a  [DEPTH];
  bit             m_alct [DEPTH];
  bit             m_tmb  [DEPTH];
  logic [NCH-1:0] m_lct  [DEPTH];

  // Scenario description.
  int n;
  bit lp;
  int abort_c;
  bit abort_rst;
  bit en_arr [MAXC];
  int run_len;
  bit prev_late = 1'b0;
  int prev_ptr = 0;

  // Expected per-cycle values; cycle c is the c-th cycle after the start edge.
  bit             e_l1a [MAXC], e_alct [MAXC], e_tmb [MAXC];
  logic [NCH-1:0] e_lct [MAXC];
  bit             e_busy [MAXC], e_done [MAXC], e_late [MAXC];
  int             e_ptr [MAXC];

  // Timeline model: each pass starts counting at its first RUN cycle s; an event
  // fires in the first enabled cycle, not before the cycle after the previous fire,
  // whose count of enabled RUN cycles so far has reached its timestamp.
  task automatic build_model();
    int s, c, cnt, prev;
    bit fin;
    for (int k = 0; k < MAXC; k++) begin
      e_l1a[k] = 0; e_alct[k] = 0; e_tmb[k] = 0; e_lct[k] = '0;
      e_done[k] = 0; e_busy[k] = 0; e_late[k] = prev_late; e_ptr[k] = prev_ptr;
    end
    run_len = 6;
    if (n == 0) return;
    for (int k = 1; k < MAXC; k++) begin
      e_busy[k] = 1; e_late[k] = 0; e_ptr[k] = 0;
    end
    s = 2; prev = 0; fin = 0; run_len = MAXC - 1;
    while (!fin) begin
      for (int i = 0; i < n && !fin; i++) begin
        c = (i == 0) ? s : prev + 1;
        cnt = 0;
        for (int j = s; j < c; j++) cnt += int'(en_arr[j]);
        while (!(en_arr[c] && cnt >= m_ts[i])) begin
          cnt += int'(en_arr[c]);
          c++;
          if (c >= MAXC - 3) begin fin = 1; break; end
        end
        if (!fin) begin
          e_l1a[c+1] = m_l1a[i]; e_alct[c+1] = m_alct[i];
          e_tmb[c+1] = m_tmb[i]; e_lct[c+1] = m_lct[i];
          if (cnt > m_ts[i]) for (int k = c + 1; k < MAXC; k++) e_late[k] = 1;
          if (i != n - 1) for (int k = c + 1; k < MAXC; k++) e_ptr[k] = i + 1;
          else if (lp) for (int k = c + 1; k < MAXC; k++) e_ptr[k] = 0;
          prev = c;
        end
      end
      if (!fin) begin
        if (lp) begin
          s = prev + 2;
          if (s >= MAXC - 3) fin = 1;
        end else begin
          e_done[prev+1] = 1;
          for (int k = prev + 2; k < MAXC; k++) e_busy[k] = 0;
          run_len = prev + 4;
          fin = 1;
        end
      end
    end
    if (abort_c > 0) begin
      for (int k = abort_c + 1; k < MAXC; k++) begin
        e_l1a[k] = 0; e_alct[k] = 0; e_tmb[k] = 0; e_lct[k] = '0;
        e_busy[k] = 0; e_done[k] = 0;
        e_ptr[k]  = abort_rst ? 0 : e_ptr[abort_c];
        e_late[k] = abort_rst ? 1'b0 : e_late[abort_c];
      end
      if (lp || run_len < abort_c + 4) run_len = abort_c + 4;
    end
  endtask

  task automatic set_ent(input int i, input int ts, input bit l, input bit a, input bit t,
                         input logic [NCH-1:0] lc);
    m_ts[i] = ts; m_l1a[i] = l; m_alct[i] = a; m_tmb[i] = t; m_lct[i] = lc;
  endtask

  task automatic load_mem(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_ts = TS_W'(m_ts[i]);
      wr_l1a = m_l1a[i]; wr_alct_dav = m_alct[i]; wr_tmb_dav = m_tmb[i]; wr_lct = m_lct[i];
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
  endtask

  task automatic en_all_on();
    for (int k = 0; k < MAXC; k++) en_arr[k] = 1'b1;
  endtask

  task automatic run_scenario(input string name);
    build_model();
    n_events = (AW+1)'(n); loop_mode = lp; start = 1'b1; en = en_arr[0];
    for (int c = 1; c <= run_len; c++) begin
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0; rst = 1'b0; wr_en = 1'b0;
      chk($sformatf("%s l1a@%0d", name, c), 32'(l1a), 32'(e_l1a[c]));
      chk($sformatf("%s alct@%0d", name, c), 32'(alct_dav), 32'(e_alct[c]));
      chk($sformatf("%s tmb@%0d", name, c), 32'(tmb_dav), 32'(e_tmb[c]));
      chk($sformatf("%s lct@%0d", name, c), 32'(lct), 32'(e_lct[c]));
      chk($sformatf("%s busy@%0d", name, c), 32'(busy), 32'(e_busy[c]));
      chk($sformatf("%s done@%0d", name, c), 32'(done), 32'(e_done[c]));
      chk($sformatf("%s late@%0d", name, c), 32'(late_err), 32'(e_late[c]));
      chk($sformatf("%s ptr@%0d", name, c), 32'(ev_ptr), 32'(e_ptr[c]));
      en = en_arr[c];
      // Junk writes while playback is active must be dropped.
      if (e_busy[c] && ($urandom_range(0, 2) == 0)) begin
        wr_en = 1'b1; wr_addr = AW'($urandom_range(0, DEPTH - 1));
        wr_ts = TS_W'($urandom); wr_l1a = 1'b1; wr_alct_dav = 1'b1; wr_tmb_dav = 1'b1;
        wr_lct = NCH'($urandom);
      end
      if (c == abort_c) begin
        if (abort_rst) rst = 1'b1;
        else stop = 1'b1;
      end
    end
    prev_late = e_late[run_len];
    prev_ptr  = e_ptr[run_len];
    @(posedge clk); #1;
    rst = 1'b0; stop = 1'b0; wr_en = 1'b0; en = 1'b1;
  endtask

  initial begin
    int t;
    // Reset state.
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst l1a", 32'(l1a), 0);
    chk("rst alct", 32'(alct_dav), 0);
    chk("rst tmb", 32'(tmb_dav), 0);
    chk("rst lct", 32'(lct), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst late", 32'(late_err), 0);
    chk("rst ptr", 32'(ev_ptr), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++)
      set_ent(i, $urandom_range(0, 40), 1'($urandom), 1'($urandom), 1'($urandom), NCH'($urandom));
    load_mem(DEPTH);

    // Two spaced events, single shot.
    set_ent(0, 5, 1, 0, 0, 7'h01); set_ent(1, 9, 0, 1, 1, 7'h40);
    load_mem(2); n = 2; lp = 0; abort_c = 0; abort_rst = 0; en_all_on();
    run_scenario("basic");

    // Adjacent timestamps.
    set_ent(0, 3, 1, 0, 0, 7'h03); set_ent(1, 4, 0, 0, 1, 7'h0c);
    load_mem(2); n = 2; lp = 0; abort_c = 0; en_all_on();
    run_scenario("adjacent");

    // Looping single entry, then stop.
    set_ent(0, 2, 1, 1, 0, 7'h11);
    load_mem(1); n = 1; lp = 1; abort_c = 21; abort_rst = 0; en_all_on();
    run_scenario("loop");

    // Pause of 4 cycles while waiting.
    set_ent(0, 6, 1, 0, 1, 7'h22);
    load_mem(1); n = 1; lp = 0; abort_c = 0; en_all_on();
    for (int k = 4; k < 8; k++) en_arr[k] = 1'b0;
    run_scenario("pause");

    // Decreasing timestamp -> late.
    set_ent(0, 10, 1, 0, 0, 7'h00); set_ent(1, 4, 0, 1, 0, 7'h55);
    load_mem(2); n = 2; lp = 0; abort_c = 0; en_all_on();
    run_scenario("late");

    // Reset mid-run, then replay without reloading.
    set_ent(0, 5, 1, 0, 0, 7'h01); set_ent(1, 9, 0, 1, 1, 7'h40);
    load_mem(2); n = 2; lp = 0; abort_c = 6; abort_rst = 1; en_all_on();
    run_scenario("midrst");
    abort_c = 0; abort_rst = 0;
    run_scenario("replay");

    // Zero-length start is ignored.
    n = 0; lp = 0; abort_c = 0;
    run_scenario("nzero");

    for (int r = 0; r < 14; r++) begin
      if (r % 4 != 3) begin
        t = 0;
        for (int i = 0; i < DEPTH; i++) begin
          if ($urandom_range(0, 7) == 0) t = $urandom_range(0, t);
          else t = t + $urandom_range(0, 6);
          set_ent(i, t, 1'($urandom), 1'($urandom), 1'($urandom), NCH'($urandom));
        end
        load_mem(DEPTH);
      end else begin
        @(posedge clk); #1;
      end
      n = $urandom_range(1, DEPTH);
      lp = ($urandom_range(0, 3) == 0);
      abort_rst = 0;
      if (lp) abort_c = $urandom_range(15, 100);
      else if ($urandom_range(0, 4) == 0) abort_c = $urandom_range(3, 30);
      else abort_c = 0;
      for (int k = 0; k < MAXC; k++) en_arr[k] = ($urandom_range(0, 9) != 0);
      run_scenario($sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
